// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single memory port between instruction fetch and data access.
// Serves one requester at a time and drives a registered command to the memory.
// Starts a handover to the other port on the same edge that completes an access.
// A wait counter times out an access that memory never answers and sets a sticky err.
// Optional macro ARB_RR_EN: when defined, conflicts are resolved round-robin.
// When ARB_RR_EN is undefined, the data port always wins a conflict.
module mem_port_arbiter #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_done,
    output logic [31:0] dm_rdata,
    output logic        dm_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rdy,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    localparam int unsigned CntW = 4;
    localparam logic [CntW-1:0] WaitLimit = CntW'(WAIT_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    state_t          state;
    logic [CntW-1:0] waitCnt;
    logic            ifPend;
    logic            dmPend;
    logic            dmWins;
    logic            timeoutHit;

    // Stall requesters until their done pulse arrives.
    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

    // A port whose done is pulsing still holds its old request; do not re-grant it.
    assign ifPend = if_req & ~if_done;
    assign dmPend = dm_req & ~dm_done;

`ifdef ARB_RR_EN
    // Owner of the most recent grant made from IDLE; on conflict the other port wins.
    logic lastDm;
    assign dmWins = ~lastDm;
`else
    assign dmWins = 1'b1;
`endif

    // Timeout fires on the WAIT_MAX-th busy cycle without a memory answer.
    always_comb begin
        timeoutHit = 1'b0;
        if ((state != IDLE) && !mem_rdy && (CntW'(waitCnt + 4'd1) == WaitLimit)) begin
            timeoutHit = 1'b1;
        end
    end

    // Arbitration FSM with registered memory command, done pulses and read data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            waitCnt   <= '0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
`ifdef ARB_RR_EN
            lastDm    <= 1'b0;
`endif
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dmPend && (!ifPend || dmWins)) begin
                        state     <= DM_BUSY;
                        waitCnt   <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_be    <= dm_be;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
`ifdef ARB_RR_EN
                        lastDm    <= 1'b1;
`endif
                    end else if (ifPend) begin
                        state     <= IF_BUSY;
                        waitCnt   <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'hF;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
`ifdef ARB_RR_EN
                        lastDm    <= 1'b0;
`endif
                    end
                end
                IF_BUSY: begin
                    if (mem_rdy || timeoutHit) begin
                        if_done  <= 1'b1;
                        if_rdata <= mem_rdy ? mem_rdata : '0;
                        if (timeoutHit) begin
                            err <= 1'b1;
                        end
                        if (mem_rdy && dmPend) begin
                            state     <= DM_BUSY;
                            waitCnt   <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= dm_we;
                            mem_be    <= dm_be;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                        end
                    end else begin
                        waitCnt <= CntW'(waitCnt + 4'd1);
                    end
                end
                DM_BUSY: begin
                    if (mem_rdy || timeoutHit) begin
                        dm_done <= 1'b1;
                        // Stores leave the last load data untouched, even on timeout.
                        if (!mem_we) begin
                            dm_rdata <= mem_rdy ? mem_rdata : '0;
                        end
                        if (timeoutHit) begin
                            err <= 1'b1;
                        end
                        if (mem_rdy && ifPend) begin
                            state     <= IF_BUSY;
                            waitCnt   <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_be    <= 4'hF;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                        end
                    end else begin
                        waitCnt <= CntW'(waitCnt + 4'd1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected done data/cycle,
// a negedge monitor pops and compares on every done pulse and every memory write.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [3:0]  dm_be = '0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rdy = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err;

    mem_port_arbiter #(.WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          cycle;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wr_t;

    exp_t ifQ[$];
    exp_t dmQ[$];
    wr_t  wrQ[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rdyDelay = 1;
    int memCnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2008_000A;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory model: answers in the rdyDelay-th cycle of each request (0 = never).
    always @(posedge clk) begin
        #1;
        if (!mem_req || mem_rdy) memCnt = 0;
        if (mem_req) memCnt++;
        mem_rdy   = mem_req && (rdyDelay != 0) && (memCnt == rdyDelay);
        mem_rdata = memRead(mem_addr);
    end

    // Monitor: pop and compare expected responses whenever the DUT presents one.
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (if_done) begin
            checks++;
            if (ifQ.size() == 0) begin
                failures++;
                $display("FAIL if_done unexpected pulse at cycle %0d", cyc);
            end else begin
                e = ifQ.pop_front();
                if (if_rdata !== e.data || cyc != e.cycle) begin
                    failures++;
                    $display("FAIL if_done rdata=%h cycle=%0d expected rdata=%h cycle=%0d",
                             if_rdata, cyc, e.data, e.cycle);
                end
            end
        end
        if (dm_done) begin
            checks++;
            if (dmQ.size() == 0) begin
                failures++;
                $display("FAIL dm_done unexpected pulse at cycle %0d", cyc);
            end else begin
                e = dmQ.pop_front();
                if (dm_rdata !== e.data || cyc != e.cycle) begin
                    failures++;
                    $display("FAIL dm_done rdata=%h cycle=%0d expected rdata=%h cycle=%0d",
                             dm_rdata, cyc, e.data, e.cycle);
                end
            end
        end
        if (mem_req && mem_rdy && mem_we) begin
            checks++;
            if (wrQ.size() == 0) begin
                failures++;
                $display("FAIL mem_write unexpected write addr=%h at cycle %0d", mem_addr, cyc);
            end else begin
                w = wrQ.pop_front();
                if (mem_addr !== w.addr || mem_wdata !== w.wdata || mem_be !== w.be) begin
                    failures++;
                    $display("FAIL mem_write addr=%h wdata=%h be=%h expected addr=%h wdata=%h be=%h",
                             mem_addr, mem_wdata, mem_be, w.addr, w.wdata, w.be);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic runIf(input logic [31:0] addr, input logic [31:0] expData, input int lat);
        exp_t e;
        int n;
        e.data = expData;
        e.cycle = cyc + lat;
        ifQ.push_back(e);
        if_addr = addr;
        if_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_done && n < 60);
        if (!if_done) begin
            checks++;
            failures++;
            $display("FAIL if_wait no if_done within %0d cycles", n);
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic runDm(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] expData, input int lat);
        exp_t e;
        wr_t w;
        int n;
        e.data = expData;
        e.cycle = cyc + lat;
        dmQ.push_back(e);
        if (we) begin
            w.addr = addr;
            w.wdata = wdata;
            w.be = be;
            wrQ.push_back(w);
        end
        dm_we = we;
        dm_be = be;
        dm_addr = addr;
        dm_wdata = wdata;
        dm_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dm_done && n < 60);
        if (!dm_done) begin
            checks++;
            failures++;
            $display("FAIL dm_wait no dm_done within %0d cycles", n);
        end
        @(posedge clk);
        #1;
        dm_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        idle(3);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_if_done", 32'(if_done), 32'h0);
        chk("rst_dm_done", 32'(dm_done), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);

        // First conflict after reset: data port first, fetch back-to-back.
        rdyDelay = 1;
        fork
            runDm(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, 2);
            runIf(32'h3000, 32'h2008_000A, 3);
        join
        idle(2);

        // Second conflict: reversed under round-robin.
        fork
`ifdef ARB_RR_EN
            runDm(1'b0, 4'hF, 32'h20, 32'h0, 32'h5A5A_0020, 3);
            runIf(32'h3004, 32'h5A5A_3004, 2);
`else
            runDm(1'b0, 4'hF, 32'h20, 32'h0, 32'h5A5A_0020, 2);
            runIf(32'h3004, 32'h5A5A_3004, 3);
`endif
        join
        idle(2);

        // Single fetch with cycle-by-cycle stall and command checks.
        fork
            runIf(32'h3000, 32'h2008_000A, 2);
            begin
                @(negedge clk);
                chk("fetch_c0_stall", 32'(if_stall), 32'h1);
                chk("fetch_c0_mem_req", 32'(mem_req), 32'h0);
                @(negedge clk);
                chk("fetch_c1_mem_req", 32'(mem_req), 32'h1);
                chk("fetch_c1_mem_addr", mem_addr, 32'h3000);
                chk("fetch_c1_mem_we", 32'(mem_we), 32'h0);
                chk("fetch_c1_stall", 32'(if_stall), 32'h1);
                @(negedge clk);
                chk("fetch_c2_stall", 32'(if_stall), 32'h0);
            end
        join
        idle(2);
        chk("dm_rdata_held", dm_rdata, 32'h5A5A_0020);

        // Slow memory write: command stable across 5 wait cycles.
        rdyDelay = 5;
        fork
            runDm(1'b1, 4'h3, 32'h44, 32'h0000_BEEF, 32'h5A5A_0020, 6);
            begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!mem_req && n < 10);
                for (int i = 0; i < 5; i++) begin
                    chk("slow_mem_addr", mem_addr, 32'h44);
                    chk("slow_mem_wdata", mem_wdata, 32'h0000_BEEF);
                    @(negedge clk);
                end
            end
        join
        chk("slow_err", 32'(err), 32'h0);
        idle(2);

        // Timeout: memory never answers.
        rdyDelay = 0;
        runIf(32'h3008, 32'h0, 16);
        @(negedge clk);
        chk("timeout_err", 32'(err), 32'h1);
        chk("timeout_mem_req", 32'(mem_req), 32'h0);
        chk("timeout_if_rdata", if_rdata, 32'h0);
        @(posedge clk);
        #1;
        rdyDelay = 1;
        runDm(1'b0, 4'hF, 32'h24, 32'h0, 32'h5A5A_0024, 2);
        @(negedge clk);
        chk("err_sticky", 32'(err), 32'h1);
        idle(2);

        // Reset during the second DM_BUSY cycle.
        rdyDelay = 0;
        dm_we = 1'b0;
        dm_be = 4'hF;
        dm_addr = 32'h28;
        dm_req = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_busy_mem_req", 32'(mem_req), 32'h1);
        @(negedge clk);
        chk("rstmid_mem_req", 32'(mem_req), 32'h0);
        chk("rstmid_mem_addr", mem_addr, 32'h0);
        chk("rstmid_mem_be", 32'(mem_be), 32'h0);
        chk("rstmid_dm_done", 32'(dm_done), 32'h0);
        chk("rstmid_dm_rdata", dm_rdata, 32'h0);
        chk("rstmid_if_rdata", if_rdata, 32'h0);
        chk("rstmid_err", 32'(err), 32'h0);
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        rst = 1'b1;
        idle(3);

        // Normal operation resumes after reset.
        rdyDelay = 1;
        runIf(32'h3000, 32'h2008_000A, 2);
        idle(3);

        chk("ifq_empty", 32'(ifQ.size()), 32'h0);
        chk("dmq_empty", 32'(dmQ.size()), 32'h0);
        chk("wrq_empty", 32'(wrQ.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WAIT_MAX, default 15: cycles a granted access may wait for mem_rdy before timeout (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 if_req  input  1  instruction fetch request; held high until if_done.
REQ-005 if_addr  input  32  fetch address; stable while if_req high.
REQ-006 if_done  output  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-007 if_rdata  output  32  fetched instruction word.
REQ-008 if_stall  output  1  if_req & ~if_done; freezes PC and IF/ID register.
REQ-009 dm_req, dm_we  input  1 each  data access request; write when dm_we=1; held until dm_done.
REQ-010 dm_be  input  4  byte enables for writes (sb/sh/sw).
REQ-011 dm_addr, dm_wdata  input  32 each  data address, store data.
REQ-012 dm_done  output  1  one-cycle pulse: data access complete.
REQ-013 dm_rdata  output  32  load data.
REQ-014 dm_stall  output  1  dm_req & ~dm_done; freezes all pipeline registers up to EX/MEM.
REQ-015 mem_req, mem_we  output  1 each  shared memory port request, write strobe.
REQ-016 mem_be  output  4; mem_addr, mem_wdata  output  32 each  shared port command.
REQ-017 mem_rdy  input  1  memory completes the current access this cycle; mem_rdata valid.
REQ-018 mem_rdata  input  32  memory read data.
REQ-019 err  output  1  sticky timeout flag.

Function
REQ-020 FSM states IDLE, IF_BUSY, DM_BUSY; the block SHALL serve exactly one requester at a time.
REQ-021 IDLE: any pending request SHALL latch the winner's command into registers and move to its BUSY state next edge; mem_req SHALL be registered (first asserted the cycle after grant).
REQ-022 BUSY: mem_req, mem_we, mem_be, mem_addr, mem_wdata SHALL stay constant until the cycle mem_rdy=1; mem_we=0 for IF accesses.
REQ-023 On mem_rdy in BUSY: mem_rdata SHALL be registered into the owner's rdata, owner's done pulses next cycle for exactly one cycle; rdata held until next completion of that port.
REQ-024 Minimum latency request-to-done SHALL be 2 cycles when memory answers in the first mem_req cycle.
REQ-025 On completion, if the other port's request is pending the FSM SHALL go directly to that port's BUSY (no IDLE bubble); the just-served port is not re-granted while its done pulses.
REQ-026 Simultaneous if_req and dm_req SHALL be resolved by the arbitration policy (REQ-033).
REQ-027 A 4-bit wait counter SHALL clear on entering BUSY and increment each BUSY cycle without mem_rdy.
REQ-028 When the counter reaches WAIT_MAX without mem_rdy: err SHALL set, owner's done SHALL pulse with rdata=0, mem_req SHALL drop, FSM returns to IDLE.
REQ-029 mem_rdy outside BUSY SHALL be ignored.
REQ-030 Writes SHALL return dm_rdata unchanged.

Reset
REQ-031 rst=0 at a rising edge SHALL force IDLE, counter 0, err 0, mem_req/mem_we 0, mem_be/mem_addr/mem_wdata 0, if_done/dm_done 0, if_rdata/dm_rdata 0, regardless of any access in flight.
REQ-032 An access aborted by reset SHALL NOT produce a done pulse; requesters re-issue after reset.

Configuration
REQ-033 Macro ARB_RR_EN: defined -> round-robin, a one-bit last-owner register (reset: IF) grants the port not served last on conflict; undefined -> fixed priority, data port always wins conflicts (older instruction first).

Verification
REQ-034 Single fetch: if_req, if_addr=0x3000, mem_rdy first cycle with mem_rdata=0x2008000A -> mem_req cycle 1, if_done cycle 2, if_rdata=0x2008000A, if_stall high cycles 0-1.
REQ-035 Conflict: if_req and dm_req (dm_we=1, addr 0x10, wdata 0xDEADBEEF, be 0xF) same cycle, rdy immediate -> fixed: DM served first, IF granted back-to-back with no idle cycle; ARB_RR_EN: same first grant after reset (last-owner=IF), reversed on a second conflict.
REQ-036 Slow memory: mem_rdy after 5 cycles -> mem_addr/mem_wdata constant across all 5, single done pulse, err stays 0.
REQ-037 Timeout: WAIT_MAX=15, mem_rdy never asserted -> done pulse with rdata=0 after 15 wait cycles, err=1 and remains 1 until rst.
REQ-038 Reset mid-access: rst=0 during DM_BUSY cycle 2 -> next edge mem_req=0, state IDLE, no dm_done pulse, all outputs zero.
